// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO and sends each byte as an 8N1-style UART frame (start, LSB-first data, stop).
// Start bit begins 2 cycles after a non-empty FIFO is seen; frames never stall once started, new pops only when enabled.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  output logic                   tx,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frames_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  baud_last;
  logic                  start_ok;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign start_ok  = enable && !fifo_empty;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx is decoded from state so reset forces the line high without waiting for a clock.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    tx        = 1'b1;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_POP;
      end
      S_POP: begin
        fifo_pop  = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (baud_last) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = shreg[0];
        if (baud_last && (bit_cnt == BIT_LAST)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (baud_last) state_nxt = start_ok ? S_POP : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          shreg    <= fifo_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        S_START, S_DATA, S_STOP: begin
          baud_cnt <= baud_last ? '0 : baud_cnt + BAUD_W'(1);
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
      if ((state == S_DATA) && baud_last) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if ((state == S_STOP) && baud_last) begin
        frames_sent <= frames_sent + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: a FIFO model feeds the DUT, a line monitor decodes frames and checks them against expected bytes.
module tb_fifo_uart_tx;
  localparam int DW        = 8;
  localparam int CPB       = 4;
  localparam int CW        = 4;
  localparam int FRAME_LEN = (DW + 2) * CPB;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          tx;
  logic          busy;
  logic [CW-1:0] frames_sent;

  int checks;
  int failures;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  // monitor state
  int                   pop_cnt;
  int                   gap_checks;
  int                   cyc;
  int                   pop_cyc;
  int                   k;
  int                   gap;
  bit                   in_frame;
  bit                   have_prev;
  bit                   gap_busy;
  logic [FRAME_LEN-1:0] bits;

  // fifo model state
  bit                   pend;
  logic [DW-1:0]        nxt_data;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b, input bit expect_tx);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int max);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", {31'd0, tx}, 32'd0);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Registered-output FIFO: the popped word appears on fifo_data during the cycle after the pop.
  initial begin
    pend      = 1'b0;
    nxt_data  = '0;
    fifo_data = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        fifo_data = nxt_data;
        pend      = 1'b0;
      end
      if (fifo_pop === 1'b1 && rst_n === 1'b1) begin
        check("pop_safe", {31'd0, fifo_q.size() != 0}, 32'd1);
        if (fifo_q.size() != 0) begin
          nxt_data = fifo_q.pop_front();
          pend     = 1'b1;
        end
        fifo_empty = (fifo_q.size() == 0);
      end
    end
  end

  // Line monitor: captures every cycle of a frame, then checks shape, payload, start latency and inter-frame gap.
  initial begin
    logic [DW-1:0] d;
    bit ok;
    pop_cnt    = 0;
    gap_checks = 0;
    cyc        = 0;
    pop_cyc    = -100;
    k          = 0;
    gap        = 0;
    in_frame   = 1'b0;
    have_prev  = 1'b0;
    gap_busy   = 1'b0;
    bits       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        in_frame  = 1'b0;
        have_prev = 1'b0;
        gap       = 0;
      end else begin
        if (fifo_pop === 1'b1) begin
          pop_cnt++;
          pop_cyc = cyc;
        end
        if (!in_frame) begin
          if (tx === 1'b0) begin
            check("start_latency", cyc - pop_cyc, 32'd2);
            if (have_prev && gap_busy) begin
              check("frame_gap", gap, 32'd2);
              gap_checks++;
            end
            bits     = '0;
            bits[0]  = tx;
            k        = 1;
            in_frame = 1'b1;
          end else begin
            gap++;
            if (busy !== 1'b1) gap_busy = 1'b0;
          end
        end else begin
          bits[k] = tx;
          k++;
          if (k == FRAME_LEN) begin
            ok = 1'b1;
            for (int bi = 0; bi < DW + 2; bi++)
              for (int c = 0; c < CPB; c++)
                if (bits[bi*CPB+c] !== bits[bi*CPB]) ok = 1'b0;
            if (bits[0] !== 1'b0 || bits[FRAME_LEN-CPB] !== 1'b1) ok = 1'b0;
            for (int j = 0; j < DW; j++) d[j] = bits[(j+1)*CPB];
            check("frame_shape", {31'd0, ok}, 32'd1);
            check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("frame_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
            in_frame  = 1'b0;
            have_prev = 1'b1;
            gap       = 0;
            gap_busy  = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int g0;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    enable     = 1'b1;
    fifo_empty = 1'b1;

    // reset and quiet idle with an empty FIFO
    repeat (3) @(negedge clk);
    check("reset_state", {25'd0, tx, fifo_pop, busy, frames_sent}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_after_reset", {25'd0, tx, fifo_pop, busy, frames_sent}, {25'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    end

    // single byte 0xA5
    do_reset();
    p0 = pop_cnt;
    push(8'hA5, 1'b1);
    wait_idle(200);
    check("t2_pops", pop_cnt - p0, 32'd1);
    check("t2_frames", {28'd0, frames_sent}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);

    // back-to-back frames
    do_reset();
    p0 = pop_cnt;
    g0 = gap_checks;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    wait_idle(600);
    check("t3_pops", pop_cnt - p0, 32'd3);
    check("t3_frames", {28'd0, frames_sent}, 32'd3);
    check("t3_gap_checks", gap_checks - g0, 32'd2);

    // enable gating
    do_reset();
    enable = 1'b0;
    p0 = pop_cnt;
    push(8'h11, 1'b1);
    push(8'h22, 1'b0);
    repeat (100) @(negedge clk);
    check("t4_no_pop", pop_cnt - p0, 32'd0);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_start(20);
    repeat (13) @(negedge clk);
    enable = 1'b0;
    wait_idle(200);
    repeat (40) @(negedge clk);
    check("t4_pops", pop_cnt - p0, 32'd1);
    check("t4_frames", {28'd0, frames_sent}, 32'd1);
    check("t4_fifo_left", fifo_q.size(), 32'd1);
    fifo_q.delete();
    fifo_empty = 1'b1;

    // reset during data bit 5 of 0x5A
    do_reset();
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    enable = 1'b1;
    wait_start(20);
    repeat (25) @(negedge clk);
    check("t5_bit5_low", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_tx", {31'd0, tx}, 32'd1);
    check("t5_async_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle(300);
    check("t5_frames", {28'd0, frames_sent}, 32'd1);

    // counter wrap at 16
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      push(DW'(i * 7), 1'b1);
      wait_idle(200);
      check($sformatf("t6_count_%0d", i), {28'd0, frames_sent}, i % 16);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
